// File: rtl/riscv_data_mem_ctrl.sv
// Byte-enabled data memory for the LSU with a fixed, parameterised access latency.
// One transaction in flight at a time: IDLE -> BUSY (LATENCY cycles) -> DONE (ready pulse).
module riscv_data_mem_ctrl #(
  parameter int MEM_SIZE_WORDS = 1024,
  parameter int LATENCY        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
);

  localparam int        AW       = $clog2(MEM_SIZE_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;

  logic          accept;
  logic          access;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= mem_we_i;
        be_q   <= mem_be_i;
        addr_q <= mem_addr_i;
        wd_q   <= mem_wd_i;
      end
    end
  end

  // The access uses only latched values so the LSU may drop or change inputs after acceptance.
  assign in_range    = (addr_q >> (AW + 2)) == 32'd0;
  assign idx         = addr_q[AW+1:2];
  assign wr_en       = access & we_q & in_range & ~rst_i;
  assign rd_en       = access & ~we_q;
  assign mem_ready_o = (state_q == DONE);

  // One byte-wide array per lane keeps each lane a simple single-port RAM with its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [MEM_SIZE_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (wr_en && be_q[gi]) begin
        mem_q[idx] <= wd_q[8*gi +: 8];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_q <= 8'h00;
      end else if (rd_en) begin
        rd_q <= in_range ? mem_q[idx] : 8'h00;
      end
    end

    assign mem_rd_o[8*gi +: 8] = rd_q;
  end

endmodule

// File: tb/tb_riscv_data_mem_ctrl.sv
// Bench for riscv_data_mem_ctrl: directed vector table, reset/held-request sequences,
// then random traffic against a word-array reference model.
module tb_riscv_data_mem_ctrl;

  localparam int LATENCY        = 2;
  localparam int MEM_SIZE_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  riscv_data_mem_ctrl #(
    .MEM_SIZE_WORDS(MEM_SIZE_WORDS),
    .LATENCY       (LATENCY)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mem_req_i  (mem_req),
    .mem_we_i   (mem_we),
    .mem_be_i   (mem_be),
    .mem_addr_i (mem_addr),
    .mem_wd_i   (mem_wd),
    .mem_rd_o   (mem_rd),
    .mem_ready_o(mem_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] model_mem[16];
  logic [31:0] model_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge. Drops the request right after acceptance and scrambles inputs.
  task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string name);
    int cyc;
    bit seen;
    mem_req  = 1'b1;
    mem_we   = we;
    mem_be   = be;
    mem_addr = addr;
    mem_wd   = wd;
    cyc  = 0;
    seen = 1'b0;
    @(posedge clk);
    cyc = 1;
    #1;
    mem_req  = 1'b0;
    mem_we   = 1'($urandom);
    mem_be   = 4'($urandom);
    mem_addr = $urandom;
    mem_wd   = $urandom;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    chk({name, "_ready_cycle"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(LATENCY + 1));
    chk({name, "_rd"}, mem_rd, exp_rd);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_pulse_width"}, {31'd0, mem_ready}, 32'd0);
    $display("txn %s we=%0b be=%b addr=%h wd=%h rd=%h exp=%h", name, we, be, addr, wd, mem_rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stamps[2];
    int n;
    int t;
    int pulses;
    logic        r_we;
    logic        r_oor;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    int          r_word;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 4'h4, 32'h0000_0020, 32'hAAAAAAAA, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'h11AA3344};
    tbl[5]  = '{1'b0, 4'h1, 32'h0000_0023, 32'h0,        32'h11AA3344};
    tbl[6]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFEF00D, 32'h11AA3344};
    tbl[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, 32'h11AA3344};
    tbl[8]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,        32'h0000_0000};
    tbl[9]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'hCAFEF00D};
    tbl[10] = '{1'b1, 4'h0, 32'h0000_0010, 32'h12345678, 32'hCAFEF00D};
    tbl[11] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    tbl[12] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h01020304, 32'hDEADBEEF};
    tbl[13] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,        32'h01020304};

    // Reset held with a request pending: nothing may be accepted.
    rst      = 1'b1;
    mem_req  = 1'b1;
    mem_we   = 1'b1;
    mem_be   = 4'hF;
    mem_addr = 32'h40;
    mem_wd   = 32'h55555555;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset_rd", mem_rd, 32'h0);
    rst     = 1'b0;
    mem_req = 1'b0;
    pulses  = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    chk("reset_no_accept", 32'(pulses), 32'd0);

    // Short reset, then a request in the very first cycle after release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      do_txn(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Reset during the access cycle aborts the write.
    do_txn(1'b1, 4'hF, 32'h30, 32'h0BADCAFE, 32'h01020304, "rst_pre_wr");
    do_txn(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, "rst_pre_rd");
    mem_req  = 1'b1;
    mem_we   = 1'b1;
    mem_be   = 4'hF;
    mem_addr = 32'h30;
    mem_wd   = 32'h12345678;
    @(posedge clk);
    #1 mem_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = mem_ready ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_rd", mem_rd, 32'h0);
    repeat (6) begin
      if (mem_ready) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_mid_no_ready", 32'(pulses), 32'd0);
    do_txn(1'b0, 4'hF, 32'h30, 32'h0, 32'h0BADCAFE, "rst_post_rd");

    // Request held high across two back-to-back reads.
    n = 0;
    t = 0;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_be   = 4'hF;
    mem_addr = 32'h10;
    while (n < 2 && t < 30) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (mem_ready) begin
        stamps[n] = t;
        n++;
        chk("held_rd", mem_rd, 32'hDEADBEEF);
        $display("held pulse %0d at cycle %0d rd=%h", n, t, mem_rd);
      end
    end
    mem_req = 1'b0;
    chk("held_pulse_count", 32'(n), 32'd2);
    if (n == 2) chk("held_spacing", 32'(stamps[1] - stamps[0]), 32'(LATENCY + 2));
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    chk("held_no_third", 32'(pulses), 32'd0);

    // Random traffic over words 0..15 plus out-of-range addresses.
    model_rd = 32'hDEADBEEF;
    for (int w = 0; w < 16; w++) begin
      model_mem[w] = $urandom;
      do_txn(1'b1, 4'hF, 32'(w * 4), model_mem[w], model_rd, $sformatf("init%0d", w));
    end
    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom);
      r_be   = 4'($urandom);
      r_wd   = $urandom;
      r_oor  = ($urandom_range(0, 7) == 0);
      r_word = $urandom_range(0, 15);
      r_addr = r_oor ? ($urandom | 32'h0000_1000) : 32'(r_word * 4 + $urandom_range(0, 3));
      if (r_we) begin
        if (!r_oor) begin
          for (int b = 0; b < 4; b++) begin
            if (r_be[b]) model_mem[r_word][8*b +: 8] = r_wd[8*b +: 8];
          end
        end
      end else begin
        model_rd = r_oor ? 32'h0 : model_mem[r_word];
      end
      do_txn(r_we, r_be, r_addr, r_wd, model_rd, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_data_mem_ctrl.md
RISCV_DATA_MEM_CTRL -- requirements
Module: riscv_data_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE_WORDS, default 1024: number of 32-bit words in the array, a power of two.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15: wait cycles from acceptance to the access cycle.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-005 SHALL have port mem_req_i, input, 1: access request from the LSU.
REQ-006 SHALL have port mem_we_i, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port mem_be_i, input, 4: byte enables; bit k enables byte k, bits [8k+7:8k].
REQ-008 SHALL have port mem_addr_i, input, 32: byte address.
REQ-009 SHALL have port mem_wd_i, input, 32: write data, already lane-replicated by the LSU.
REQ-010 SHALL have port mem_rd_o, output, 32: read data, full word.
REQ-011 SHALL have port mem_ready_o, output, 1: one-cycle completion pulse.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-013 IDLE with mem_req_i=1 SHALL accept the request (cycle N).
- Latch we, be, addr and wd into internal registers.
- Load the wait counter with LATENCY-1.
- Go to BUSY.
REQ-014 IDLE with mem_req_i=0 SHALL stay in IDLE.
REQ-015 In BUSY with counter != 0, the block SHALL decrement the counter and stay in BUSY.
REQ-016 In BUSY with counter == 0, the block SHALL perform the access using latched values only, then go to DONE.
REQ-017 In DONE, the block SHALL:
- Assert mem_ready_o for exactly that cycle.
- Return to IDLE.
- Ignore mem_req_i.
REQ-018 mem_ready_o SHALL be 1 only in DONE, i.e. in cycle N+LATENCY+1.
REQ-019 An accepted transaction SHALL complete even if mem_req_i falls or inputs change afterwards.
REQ-020 Minimum spacing between acceptances SHALL be LATENCY+2 cycles: a request held high through DONE is re-accepted in the following IDLE cycle.
REQ-021 Word index SHALL be mem_addr[log2(MEM_SIZE_WORDS)+1:2]; addr[1:0] ignored.
REQ-022 Write access SHALL update only the bytes whose latched be bit is 1; be=4'b0000 changes nothing but still completes with ready.
REQ-023 Read access SHALL load the full addressed word into the mem_rd_o register, regardless of be.
REQ-024 mem_rd_o SHALL hold its value until the next read access, and SHALL be unchanged by writes.
REQ-025 Out-of-range access (latched addr >= 4*MEM_SIZE_WORDS) SHALL:
- Suppress writes.
- Load 32'h0 into mem_rd_o on reads.
- Complete with normal timing.
REQ-026 LATENCY=1 SHALL give the access in N+1 and ready in N+2.

Reset
REQ-027 rst_i high at a clock edge SHALL force:
- state IDLE
- counter 0
- mem_ready_o 0
- mem_rd_o 32'h0
- latched registers 0
REQ-028 rst_i SHALL take priority over every transition; reset during BUSY aborts the transaction with no array write and no ready pulse.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 No request SHALL be accepted in a cycle where rst_i=1; acceptance is possible from the first cycle after rst_i falls.

Verification (LATENCY=2, MEM_SIZE_WORDS=1024)
REQ-031 Word write/read:
- Write addr 0x10, be 1111, wd 0xDEADBEEF.
- Then read 0x10 -> mem_rd_o=0xDEADBEEF.
- ready in N+3 for each transaction.
REQ-032 Byte enable:
- Preload 0x20 = 0x11223344.
- Write be 0100, wd 0xAAAAAAAA.
- Read 0x20 -> 0x11AA3344.
REQ-033 Held request: mem_req_i held high continuously for two reads -> ready pulses exactly 4 cycles apart, each 1 cycle wide.
REQ-034 Out of range:
- Write 0x00001000 with 0xFFFFFFFF -> ready still pulses.
- Read 0x00001000 -> 0x00000000.
- Word 0 unchanged.
REQ-035 Reset mid-op:
- Write 0x30 with 0x12345678.
- Assert rst_i in cycle N+2 -> no ready pulse, mem_rd_o=0.
- Later read of 0x30 returns its prior contents.
REQ-036 Request drop: read 0x10 with mem_req_i dropped after N -> ready still pulses in N+3 with the correct data.
